// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the packed-BCD to binary converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a 4-bit field holds a legal decimal digit (0..9).
  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Valid/ready bus between the BCD producer and the binary consumer.
interface bcd2bin_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned BIN_W   = 10
);

  localparam int unsigned BCD_W = DIGIT_W * NDIGITS;

  logic             in_valid;
  logic             in_ready;
  logic [BCD_W-1:0] bcd_in;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  // Producer/consumer side (drives BCD words, accepts results).
  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );

  // Converter side.
  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

endinterface

// File: rtl/bcd2bin_seq_sub3.sv
// Per-digit correction for reverse double-dabble: fields >= 8 lose 3.
module bcd2bin_seq_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  output logic [DIGIT_W-1:0] y_c_o
);

  // 4-bit wraparound arithmetic; no carry leaves the digit.
  always_comb begin
    y_c_o = a_i;
    if (a_i >= 4'd8) y_c_o = a_i - 4'd3;
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per cycle).
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned BIN_W   = 10
)(
  input  logic               clk,
  input  logic               reset_n,
  bcd2bin_seq_if.slave       bus
);

  localparam int unsigned BCD_W = DIGIT_W * NDIGITS;
  localparam int unsigned RW    = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t            state_q, state_d;
  logic [RW-1:0]     sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [RW-1:0]     shifted;
  logic [RW-1:0]     corrected;
  logic [BCD_W-1:0]  digits_fix;
  logic              bad_digit;

  assign shifted = sreg_q >> 1;

  // Digit correction applied to the BCD field after each right shift.
  for (genvar k = 0; k < NDIGITS; k++) begin : g_sub3
    bcd2bin_seq_sub3 u_sub3 (
      .a_i   (shifted[BIN_W + k*DIGIT_W +: DIGIT_W]),
      .y_c_o (digits_fix[k*DIGIT_W +: DIGIT_W])
    );
  end

  assign corrected = {digits_fix, shifted[BIN_W-1:0]};

  // Flag any offered digit outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (!is_bcd_digit(bus.bcd_in[k*DIGIT_W +: DIGIT_W])) bad_digit = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (bad_digit) begin
            err_d       = 1'b1;
            bin_d       = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            sreg_d  = {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_d   = CNT_LAST;
            err_d   = 1'b0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        sreg_d = corrected;
        if (cnt_q == '0) begin
          bin_d       = corrected[BIN_W-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bin_out   = bin_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq.
module tb_bcd2bin_seq;

  localparam int unsigned NDIGITS = 3;
  localparam int unsigned BIN_W   = 10;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  bcd2bin_seq_if #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word for exactly one accepting edge.
  task automatic offer(input string tag, input logic [11:0] bcd);
    bus.bcd_in   = bcd;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check latency, in_ready low while busy, and the result.
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [9:0] exp_bin, input logic exp_err);
    int lat;
    bit ir_low;
    lat    = 0;
    ir_low = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ir_low = 1'b0;
      step();
      lat++;
    end
    chk({tag, "_lat"},   32'(lat),           32'(exp_lat));
    chk({tag, "_busy"},  32'(ir_low),        32'd1);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_bin"},   32'(bus.bin_out),   32'(exp_bin));
    chk({tag, "_err"},   32'(bus.err),       32'(exp_err));
    if (!exp_err) chk({tag, "_upper0"}, 32'(dut.sreg_q[21:10]), 32'd0);
  endtask

  // Handshake the held result and confirm return to IDLE.
  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    bit hold_ok;
    bit never_valid;
    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_bin",       32'(bus.bin_out),   32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_cnt",       32'(dut.cnt_q),     32'd0);
    chk("rst_sreg",      32'(dut.sreg_q),    32'd0);
    reset_n = 1'b1;
    step();

    // 1: largest value, latency of BIN_W edges after the accept edge.
    bus.out_ready = 1'b1;
    offer("t1", 12'h999);
    chk("t1_ready_drop", 32'(bus.in_ready), 32'd0);
    wait_result("t1", 10, 10'h3E7, 1'b0);
    step();
    chk("t1_one_cycle", 32'(bus.out_valid), 32'd0);

    // 2: back-to-back words, result held one cycle each.
    offer("t2a", 12'h000);
    wait_result("t2a", 10, 10'd0, 1'b0);
    step();
    chk("t2a_one_cycle", 32'(bus.out_valid), 32'd0);
    offer("t2b", 12'h255);
    wait_result("t2b", 10, 10'd255, 1'b0);
    step();
    chk("t2b_one_cycle", 32'(bus.out_valid), 32'd0);
    offer("t2c", 12'h100);
    wait_result("t2c", 10, 10'd100, 1'b0);
    step();
    chk("t2c_one_cycle", 32'(bus.out_valid), 32'd0);

    // 3: illegal middle digit goes straight to DONE with err; next word is clean.
    offer("t3a", 12'h9A0);
    wait_result("t3a", 0, 10'd0, 1'b1);
    step();
    offer("t3b", 12'h042);
    wait_result("t3b", 10, 10'd42, 1'b0);
    step();

    // 4: back-pressure, stable result, in_valid ignored while DONE.
    bus.out_ready = 1'b0;
    offer("t4", 12'h512);
    wait_result("t4", 10, 10'd512, 1'b0);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.bcd_in   = 12'h123;
      step();
      if (!bus.out_valid || bus.bin_out != 10'd512 || bus.err || bus.in_ready) hold_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("t4_hold", 32'(hold_ok), 32'd1);
    chk("t4_bin_after_hold", 32'(bus.bin_out), 32'd512);
    release_result("t4");

    // 5: reset during the 5th CONV cycle discards the word.
    bus.out_ready = 1'b1;
    offer("t5a", 12'h777);
    for (int i = 0; i < 4; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready),  32'd1);
    never_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.out_valid) never_valid = 1'b0;
    end
    chk("t5_discarded", 32'(never_valid), 32'd1);
    offer("t5b", 12'h001);
    wait_result("t5b", 10, 10'd1, 1'b0);
    step();

    // 6: bcd_in wiggles during CONV without affecting the result.
    bus.bcd_in   = 12'h360;
    bus.in_valid = 1'b1;
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.bcd_in = 12'($urandom);
      step();
    end
    bus.bcd_in = 12'h987;
    wait_result("t6", 5, 10'd360, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
